// File: rtl/snn_pkg.sv
// Shared constants and types for the image loader that fills the SNN input RAM.
package snn_pkg;

    localparam int IMG_BYTES = 98;
    localparam int IMG_BITS  = 784;
    localparam int ADDR_W    = 10;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/img_rx_loader_uart_rx.sv
// 8N1 serial-to-byte receiver; the line input must already be synchronized to clk.
module uart_rx
    import snn_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       rx_busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_BIT = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(BAUD_DIV - 1);

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // cnt_q counts down to the next sample point; tick marks that sample cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        tick     = (cnt_q == '0);

        case (state_q)
            RX_IDLE: begin
                if (!rx) begin
                    state_d = RX_START;
                    cnt_d   = HALF_BIT;
                end
            end
            RX_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rx) begin
                    state_d = RX_DATA;
                    cnt_d   = FULL_BIT;
                    bit_d   = 3'd0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d = {rx, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                // Leave STOP on the sample cycle so a back-to-back start bit is seen
                if (!tick) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d  = RX_IDLE;
                    rx_valid = rx;
                    rx_ferr  = !rx;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign rx_byte = shift_q;
    assign rx_busy = (state_q != RX_IDLE);

endmodule

// File: rtl/img_rx_loader.sv
// Receives an image over UART and writes it bit-serially into a 1024x1 input RAM.
module img_rx_loader
    import snn_pkg::*;
#(
    parameter int BAUD_DIV  = 434,
    parameter int IMG_BYTES = snn_pkg::IMG_BYTES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      uart_rx,
    input  logic                      img_ack,
    output logic                      ram_we,
    output logic [snn_pkg::ADDR_W-1:0] ram_addr,
    output logic                      ram_din,
    output logic                      img_done,
    output logic                      busy,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int CNT_W = snn_pkg::ADDR_W - 3;

    logic [1:0]       sync_q, sync_d;
    logic             wr_active_q, wr_active_d;
    logic [2:0]       wr_idx_q, wr_idx_d;
    logic [7:0]       wr_byte_q, wr_byte_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             img_done_q, img_done_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             done_eff;

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ferr;
    logic             rx_busy;

    uart_rx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx      (sync_q[1]),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr),
        .rx_busy (rx_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 2'b11;
            wr_active_q <= 1'b0;
            wr_idx_q    <= '0;
            wr_byte_q   <= '0;
            byte_cnt_q  <= '0;
            img_done_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            wr_active_q <= wr_active_d;
            wr_idx_q    <= wr_idx_d;
            wr_byte_q   <= wr_byte_d;
            byte_cnt_q  <= byte_cnt_d;
            img_done_q  <= img_done_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // An ack is applied before the incoming byte is judged, so a coincident byte lands at 0
    always_comb begin
        sync_d      = {sync_q[0], uart_rx};
        wr_active_d = wr_active_q;
        wr_idx_d    = wr_idx_q;
        wr_byte_d   = wr_byte_q;
        byte_cnt_d  = byte_cnt_q;
        img_done_d  = img_done_q;
        frame_err_d = rx_ferr;
        overrun_d   = 1'b0;
        cnt_inc     = byte_cnt_q + CNT_W'(1);
        done_eff    = img_done_q;

        if (img_ack && img_done_q) begin
            byte_cnt_d = '0;
            img_done_d = 1'b0;
            done_eff   = 1'b0;
        end

        if (wr_active_q) begin
            wr_idx_d = wr_idx_q + 3'd1;
            if (wr_idx_q == 3'd7) begin
                wr_active_d = 1'b0;
                byte_cnt_d  = cnt_inc;
                if (cnt_inc == CNT_W'(IMG_BYTES)) begin
                    img_done_d = 1'b1;
                end
            end
        end

        if (rx_valid) begin
            if (done_eff) begin
                overrun_d = 1'b1;
            end else begin
                wr_active_d = 1'b1;
                wr_idx_d    = 3'd0;
                wr_byte_d   = rx_byte;
            end
        end
    end

    assign ram_we    = wr_active_q;
    assign ram_addr  = {byte_cnt_q, wr_idx_q};
    assign ram_din   = wr_active_q & wr_byte_q[wr_idx_q];
    assign img_done  = img_done_q;
    assign busy      = rx_busy | wr_active_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_img_rx_loader.sv
// Directed self-checking bench for img_rx_loader: UART frames in, RAM write log checked.
module tb_img_rx_loader;

    localparam int BAUD = 16;
    localparam int NB   = 98;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic       img_ack;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic       ram_din;
    logic       img_done;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    img_rx_loader #(
        .BAUD_DIV (BAUD),
        .IMG_BYTES(NB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .img_ack  (img_ack),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .img_done (img_done),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write log and pulse counters, sampled on the falling edge
    int         wr_total   = 0;
    int         ferr_total = 0;
    int         ovr_total  = 0;
    int         done_rise  = -1;
    logic       done_prev  = 1'b0;
    logic [9:0] log_addr [0:4095];
    logic       log_din  [0:4095];
    int         log_cyc  [0:4095];

    always @(negedge clk) begin
        if (ram_we === 1'b1 && wr_total < 4096) begin
            log_addr[wr_total] = ram_addr;
            log_din[wr_total]  = ram_din;
            log_cyc[wr_total]  = cyc;
            wr_total++;
        end
        if (frame_err === 1'b1) ferr_total++;
        if (overrun === 1'b1) ovr_total++;
        if (img_done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
        done_prev = img_done;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample digit "9" on a 28x28 grid: a ring on top, a right-hand stem and a bottom hook
    function automatic logic pix(input int p);
        int r;
        int c;
        logic on;
        r  = p / 28;
        c  = p % 28;
        on = 1'b0;
        if (r >= 4 && r <= 14 && c >= 8 && c <= 19 &&
            (r <= 5 || r >= 13 || c <= 9 || c >= 18)) on = 1'b1;
        if (c >= 18 && c <= 19 && r >= 4 && r <= 23) on = 1'b1;
        if (r >= 22 && r <= 23 && c >= 10 && c <= 19) on = 1'b1;
        return on;
    endfunction

    function automatic logic [7:0] rom_byte(input int i);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = pix(8 * i + j);
        return b;
    endfunction

    // frame bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit
    task automatic drive_frame(input logic [9:0] fr, input int from, input int to);
        for (int k = from; k < to; k++) begin
            uart_rx = fr[k];
            repeat (BAUD) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_frame({stop, b, 1'b0}, 0, 10);
        uart_rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
    endtask

    task automatic check_burst(input string tag, input int base, input logic [9:0] addr0,
                               input logic [7:0] exp_byte);
        logic [7:0] dv;
        dv = '0;
        check({tag, "_we_count"}, wr_total - base, 8);
        if (wr_total - base >= 8) begin
            for (int j = 0; j < 8; j++) dv[j] = log_din[base + j];
            check({tag, "_addr_first"}, log_addr[base], addr0);
            check({tag, "_addr_last"}, log_addr[base + 7], addr0 + 10'd7);
            check({tag, "_din"}, dv, exp_byte);
            check({tag, "_consecutive"}, log_cyc[base + 7] - log_cyc[base], 7);
        end
    endtask

    task automatic check_image(input string tag, input int base);
        int mism;
        mism = 0;
        check({tag, "_we_count"}, wr_total - base, 784);
        if (wr_total - base >= 784) begin
            for (int n = 0; n < 784; n++) begin
                if (log_addr[base + n] !== 10'(n) || log_din[base + n] !== pix(n)) mism++;
            end
            check({tag, "_bit_mismatches"}, mism, 0);
            check({tag, "_done_latency"}, done_rise - log_cyc[base + 783], 1);
        end
        check({tag, "_img_done"}, img_done, 1);
    endtask

    function automatic logic [15:0] out_vec();
        return {ram_we, ram_addr, ram_din, img_done, busy, frame_err, overrun};
    endfunction

    int base;
    int f0;
    int o0;

    initial begin
        rst     = 1'b1;
        uart_rx = 1'b1;
        img_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", out_vec(), 16'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] single byte 0xA5");
        base = wr_total;
        f0   = ferr_total;
        send_byte(8'hA5, 1'b1);
        check_burst("a5", base, 10'd0, 8'hA5);
        check("a5_no_ferr", ferr_total - f0, 0);
        check("a5_idle", busy, 0);

        $display("[TB] 3-cycle glitch");
        base    = wr_total;
        f0      = ferr_total;
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        check("glitch_no_write", wr_total - base, 0);
        check("glitch_no_ferr", ferr_total - f0, 0);
        check("glitch_idle", busy, 0);

        $display("[TB] framing error then good byte");
        base = wr_total;
        f0   = ferr_total;
        send_byte(8'h5A, 1'b0);
        check("ferr_pulse", ferr_total - f0, 1);
        check("ferr_no_write", wr_total - base, 0);
        base = wr_total;
        send_byte(8'h3C, 1'b1);
        check_burst("after_ferr", base, 10'd8, 8'h3C);

        $display("[TB] full image");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_image_done_low", img_done, 0);
        base = wr_total;
        for (int i = 0; i < NB; i++) send_byte(rom_byte(i), 1'b1);
        check_image("image1", base);

        $display("[TB] overrun and ack");
        base = wr_total;
        o0   = ovr_total;
        send_byte(8'hFF, 1'b1);
        check("overrun_pulse", ovr_total - o0, 1);
        check("overrun_no_write", wr_total - base, 0);
        check("overrun_done_held", img_done, 1);
        img_ack = 1'b1;
        @(negedge clk);
        img_ack = 1'b0;
        check("ack_done_low", img_done, 0);
        base = wr_total;
        send_byte(8'h81, 1'b1);
        check_burst("after_ack", base, 10'd0, 8'h81);

        $display("[TB] reset mid-byte then resend");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        base = wr_total;
        for (int i = 0; i < 5; i++) send_byte(rom_byte(i), 1'b1);
        check("pre_abort_writes", wr_total - base, 40);
        drive_frame({1'b1, rom_byte(5), 1'b0}, 0, 4);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", out_vec(), 16'h0);
        drive_frame({1'b1, rom_byte(5), 1'b0}, 4, 10);
        uart_rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BAUD) @(negedge clk);
        base = wr_total;
        for (int i = 0; i < NB; i++) send_byte(rom_byte(i), 1'b1);
        check_image("image2", base);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/img_rx_loader.md
IMG_RX_LOADER -- requirements
Module: img_rx_loader

Interface
REQ-001 Parameter BAUD_DIV, default 434, clocks per UART bit; SHALL be at least 16.
REQ-002 Parameter IMG_BYTES, default 98, number of bytes per image (98 bytes = 784 pixel bits).
REQ-003 clk  input  1  single clock domain; all logic SHALL be clocked on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 uart_rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 img_ack  input  1  one-cycle pulse from the consumer: image has been consumed, rearm loader.
REQ-007 ram_we  output  1  write strobe to the 1024x1-bit input RAM.
REQ-008 ram_addr  output  10  RAM bit address.
REQ-009 ram_din  output  1  pixel bit to write.
REQ-010 img_done  output  1  level: full image is in RAM.
REQ-011 busy  output  1  level: a frame is in progress or a byte is being written.
REQ-012 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-013 overrun  output  1  one-cycle pulse: byte received while img_done is high.

Function
REQ-014 uart_rx SHALL pass through a 2-FF synchronizer, preset to 1; all sampling SHALL use the synchronized value.
REQ-015 The receiver FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-016 IDLE -> START on a synchronized low; the bit counter loads BAUD_DIV/2.
REQ-017 START, at mid-bit: if the line is low -> DATA; if high -> IDLE (false start, no pulse).
REQ-018 DATA SHALL sample every BAUD_DIV clocks and shift LSB first; after the 8th sample -> STOP.
REQ-019 STOP, at mid-bit: if the line is high the byte is valid; if low, frame_err pulses and the byte is discarded.
REQ-020 STOP SHALL return to IDLE in the same cycle as its sample, so that a back-to-back start bit is caught.
REQ-021 On a valid byte while img_done is low, the writer SHALL issue 8 consecutive ram_we cycles, starting the cycle after the stop sample.
REQ-022 In write cycle j (j = 0..7): ram_addr = 8*byte_cnt + j and ram_din = byte[j].
REQ-023 byte_cnt SHALL increment after the 8th write.
REQ-024 When byte_cnt reaches IMG_BYTES, img_done SHALL rise the cycle after the final write and byte_cnt SHALL hold.
REQ-025 While img_done is high, valid bytes SHALL cause no writes and SHALL pulse overrun in the cycle after the stop sample.
REQ-026 img_ack while img_done is high: byte_cnt clears to 0 and img_done falls on the next edge; img_ack at any other time SHALL be ignored.
REQ-027 If img_ack and a valid stop sample occur in the same cycle, the ack SHALL take effect first and the byte SHALL be written as byte 0.
REQ-028 A frame_err byte SHALL NOT advance byte_cnt; partial images SHALL persist until further bytes arrive or reset.
REQ-029 busy SHALL be high in every state other than IDLE and during write cycles.
REQ-030 ram_we SHALL be low in every cycle not covered by REQ-021.

Reset
REQ-031 rst SHALL force FSM=IDLE, byte_cnt=0, synchronizer=1, and all outputs to 0.
REQ-032 rst during reception or a write burst SHALL abort it immediately; already-written RAM bits are not cleared.

Structure
REQ-033 snn_pkg SHALL hold IMG_BYTES, IMG_BITS=784, the RAM address width (10) and the rx state enum.
REQ-034 The serial-to-byte logic SHALL be a sub-module uart_rx (ports: byte, valid pulse, frame_err pulse).
REQ-035 img_rx_loader SHALL contain only the synchronizer, the writer and the counters.

Verification
REQ-036 Scenario 1: send 98 bytes of sample image "9" from uart_tx -> RAM matches ROM bit-for-bit at addr 8i+j; img_done rises 1 cycle after the write to addr 783.
REQ-037 Scenario 2: byte 0xA5 with BAUD_DIV=16 -> ram_we high for exactly 8 cycles, addr 0..7, din 1,0,1,0,0,1,0,1.
REQ-038 Scenario 3: low glitch of 3 clocks on uart_rx -> no write, no frame_err, FSM back to IDLE.
REQ-039 Scenario 4: byte with stop bit forced low -> one frame_err pulse, byte_cnt unchanged; the next good byte lands at the same address.
REQ-040 Scenario 5: after img_done, send 0xFF -> overrun pulse, no ram_we; then img_ack -> img_done low next cycle, and the next byte is written to addr 0..7.
REQ-041 Scenario 6: assert rst mid-DATA of byte 5 -> all outputs 0 next cycle; a full resend of 98 bytes completes normally.
